// File: rtl/cc_pkg.sv
// Shared types and constants for the colour-correction coefficient loader.
// Defaults are the OV5640 calibration set, scaled to the configured fixed-point format.
package cc_pkg;

  localparam int COEF_NUM = 12;
  localparam logic [3:0] STATUS_ADDR = 4'd12;

  typedef enum logic [3:0] {
    A11 = 4'd0, A12 = 4'd1, A13 = 4'd2,  A14 = 4'd3,
    A21 = 4'd4, A22 = 4'd5, A23 = 4'd6,  A24 = 4'd7,
    A31 = 4'd8, A32 = 4'd9, A33 = 4'd10, A34 = 4'd11
  } coef_idx_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_EOF = 2'd1,
    SEND     = 2'd2
  } state_t;

  // Calibration values in units of 1e-4, converted to sign-magnitude at elaboration.
  localparam longint DEFAULT_E4 [COEF_NUM] = '{
    64'sd19808,    -64'sd6996,  -64'sd499,    -64'sd2368427,
    -64'sd3961,    64'sd15994,  -64'sd79,     -64'sd2062747,
    64'sd617,      -64'sd10097, 64'sd22212,   -64'sd2799075
  };

  function automatic logic [63:0] default_coef(input int idx, input int px_width,
                                               input int fract_width);
    longint value;
    longint mag;
    logic [63:0] result;
    value = DEFAULT_E4[idx];
    mag   = (value < 0) ? -value : value;
    mag   = (mag * (longint'(1) << fract_width) + 64'sd5000) / 64'sd10000;
    result = 64'(mag);
    if (value < 0) result[px_width + fract_width] = 1'b1;
    return result;
  endfunction

endpackage

// File: rtl/cc_ctrl_if.sv
// Coefficient update channel between the loader (master) and the colour corrector.
interface cc_ctrl_if #(
  parameter int COEF_WIDTH = 20
);
  logic                  coef_lock;
  logic [3:0]            coef_sel;
  logic [COEF_WIDTH:0]   coef;

  modport master (output coef_lock, coef_sel, coef);
  modport slave  (input  coef_lock, coef_sel, coef);
endinterface

// File: rtl/cc_frame_tracker.sv
// Counts completed lines of the snooped video stream and pulses eof_o on the
// handshake that ends the last active line of a full-height frame.
module cc_frame_tracker #(
  parameter int FRAME_HEIGHT = 1080
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic vid_tvalid_i,
  input  logic vid_tready_i,
  input  logic vid_tuser_i,
  input  logic vid_tlast_i,
  output logic eof_o
);

  localparam int CNT_W = $clog2(FRAME_HEIGHT + 1);
  localparam logic [CNT_W-1:0] PARKED    = CNT_W'(FRAME_HEIGHT);
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(FRAME_HEIGHT - 1);

  logic [CNT_W-1:0] line_cnt;
  logic [CNT_W-1:0] line_base;
  logic             hs;

  assign hs        = vid_tvalid_i & vid_tready_i;
  // A SOF beat starts line 0 even if the counter is still parked from a previous frame.
  assign line_base = vid_tuser_i ? '0 : line_cnt;
  assign eof_o     = hs & vid_tlast_i & (line_base == LAST_LINE);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      line_cnt <= PARKED;
    end else if (hs) begin
      if (vid_tuser_i) begin
        line_cnt <= vid_tlast_i ? CNT_W'(1) : '0;
      end else if (vid_tlast_i && line_cnt < PARKED) begin
        line_cnt <= line_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/cc_coef_loader.sv
// CSR shadow bank of 12 colour-correction coefficients, streamed to the corrector on apply.
// Build option: CC_FRAME_SYNC_EN holds each burst until the end of a full video frame.
module cc_coef_loader
  import cc_pkg::*;
#(
  parameter int PX_WIDTH       = 10,
  parameter int FRACT_WIDTH    = 10,
  parameter int FRAME_HEIGHT   = 1080,
  parameter int CSR_DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      csr_wr_i,
  input  logic                      csr_rd_i,
  input  logic [3:0]                csr_addr_i,
  input  logic [CSR_DATA_WIDTH-1:0] csr_wdata_i,
  output logic [CSR_DATA_WIDTH-1:0] csr_rdata_o,
  input  logic                      csr_apply_i,
  input  logic                      vid_tvalid_i,
  input  logic                      vid_tready_i,
  input  logic                      vid_tuser_i,
  input  logic                      vid_tlast_i,
  output logic                      busy_o,
  cc_ctrl_if.master                 cc_ctrl_o
);

  localparam int COEF_WIDTH = PX_WIDTH + FRACT_WIDTH;
  localparam int COEF_W     = COEF_WIDTH + 1;

  logic [COEF_WIDTH:0] defaults [COEF_NUM];
  logic [COEF_WIDTH:0] shadow   [COEF_NUM];
  logic [COEF_WIDTH:0] staging  [COEF_NUM];

  state_t              state;
  logic [3:0]          idx;
  logic [3:0]          next_idx;
  logic                deferred;
  logic                coef_lock;
  logic [3:0]          coef_sel;
  logic [COEF_WIDTH:0] coef;
  logic                unused_bits;

  for (genvar g = 0; g < COEF_NUM; g++) begin : g_default
    localparam logic [COEF_WIDTH:0] VALUE = COEF_W'(default_coef(g, PX_WIDTH, FRACT_WIDTH));
    assign defaults[g] = VALUE;
  end

  assign next_idx = idx + 4'd1;

  assign cc_ctrl_o.coef_lock = coef_lock;
  assign cc_ctrl_o.coef_sel  = coef_sel;
  assign cc_ctrl_o.coef      = coef;

`ifdef CC_FRAME_SYNC_EN
  logic eof;

  cc_frame_tracker #(
    .FRAME_HEIGHT (FRAME_HEIGHT)
  ) u_frame_tracker (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .vid_tvalid_i (vid_tvalid_i),
    .vid_tready_i (vid_tready_i),
    .vid_tuser_i  (vid_tuser_i),
    .vid_tlast_i  (vid_tlast_i),
    .eof_o        (eof)
  );

  assign unused_bits = ^csr_wdata_i[CSR_DATA_WIDTH-1:COEF_W];
`else
  assign unused_bits = ^{csr_wdata_i[CSR_DATA_WIDTH-1:COEF_W],
                         vid_tvalid_i, vid_tready_i, vid_tuser_i, vid_tlast_i};
`endif

  // NOTE: the shadow bank is reset like any other register because its reset
  // value is the calibration set, not don't-care storage.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      shadow      <= defaults;
      csr_rdata_o <= '0;
    end else begin
      if (csr_wr_i && csr_addr_i < STATUS_ADDR) begin
        shadow[csr_addr_i] <= csr_wdata_i[COEF_WIDTH:0];
      end
      if (csr_rd_i) begin
        if (csr_addr_i < STATUS_ADDR) begin
          csr_rdata_o <= CSR_DATA_WIDTH'(shadow[csr_addr_i]);
        end else if (csr_addr_i == STATUS_ADDR) begin
          csr_rdata_o <= CSR_DATA_WIDTH'({deferred, busy_o, state});
        end else begin
          csr_rdata_o <= '0;
        end
      end
    end
  end

  // NOTE: every state and output register here is assigned with <= so that all
  // branches see the values from before the edge, exactly like the hardware.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      idx       <= '0;
      deferred  <= 1'b0;
      busy_o    <= 1'b0;
      staging   <= defaults;
      coef_lock <= 1'b0;
      coef_sel  <= '0;
      coef      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (csr_apply_i) begin
            staging <= shadow;
            busy_o  <= 1'b1;
`ifdef CC_FRAME_SYNC_EN
            state   <= WAIT_EOF;
`else
            // Staging loads at this same edge, so beat 0 comes straight from the shadow.
            state     <= SEND;
            idx       <= '0;
            coef_lock <= 1'b1;
            coef_sel  <= '0;
            coef      <= shadow[0];
`endif
          end
        end
`ifdef CC_FRAME_SYNC_EN
        WAIT_EOF: begin
          if (csr_apply_i) staging <= shadow;
          if (eof) begin
            state     <= SEND;
            idx       <= '0;
            coef_lock <= 1'b1;
            coef_sel  <= '0;
            coef      <= csr_apply_i ? shadow[0] : staging[0];
          end
        end
`endif
        SEND: begin
          if (idx != A34) begin
            idx      <= next_idx;
            coef_sel <= next_idx;
            coef     <= staging[next_idx];
            if (csr_apply_i) deferred <= 1'b1;
          end else if (deferred || csr_apply_i) begin
            staging  <= shadow;
            deferred <= 1'b0;
`ifdef CC_FRAME_SYNC_EN
            state     <= WAIT_EOF;
            coef_lock <= 1'b0;
            coef_sel  <= '0;
            coef      <= '0;
`else
            idx       <= '0;
            coef_sel  <= '0;
            coef      <= shadow[0];
`endif
          end else begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            coef_lock <= 1'b0;
            coef_sel  <= '0;
            coef      <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          busy_o    <= 1'b0;
          coef_lock <= 1'b0;
          coef_sel  <= '0;
          coef      <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/cc_coef_loader.md
Name: cc_coef_loader

Overview:
- Initiator side of cc_ctrl_if. Holds a CSR-writable shadow bank of the 12 colour-correction coefficients (3x4 affine matrix).
- On an apply request, snapshots the bank. It then streams the snapshot to the colour corrector as 12 single-cycle coef_lock writes.
- It places that burst in vertical blanking by snooping the corrector's input video stream. This avoids intra-frame coefficient tearing.

Parameters:
- PX_WIDTH, 10, pixel component width.
- FRACT_WIDTH, 10, coefficient fractional bits. COEF_WIDTH = PX_WIDTH + FRACT_WIDTH.
- FRAME_HEIGHT, 1080, active lines per frame. Used for end-of-frame detection.
- CSR_DATA_WIDTH, 32, CSR data bus width. Must be >= COEF_WIDTH + 1.

Ports:
- clk_i  in  1  sole clock.
- rst_n_i  in  1  synchronous active-low reset.
- csr_wr_i  in  1  shadow write strobe.
- csr_rd_i  in  1  read strobe.
- csr_addr_i  in  4  0..11 = coefficient index (a11,a12,a13,a14,a21..a34); 12 = status.
- csr_wdata_i  in  CSR_DATA_WIDTH  bits [COEF_WIDTH:0] = sign-magnitude coefficient; bit COEF_WIDTH = sign.
- csr_rdata_o  out  CSR_DATA_WIDTH  read data.
- csr_apply_i  in  1  single-cycle apply request.
- vid_tvalid_i, vid_tready_i, vid_tuser_i, vid_tlast_i  in  1 each  snoop of the corrector input stream (tuser = SOF, tlast = EOL).
- busy_o  out  1  high outside IDLE.
- cc_ctrl_o  cc_ctrl_if.master  -  coef_lock (1), coef_sel (4), coef (COEF_WIDTH+1).

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - Shadow and staging banks load the OV5640 calibration set from cc_pkg: {+1.9808, -0.6996, -0.0499, -236.8427, -0.3961, +1.5994, -0.0079, -206.2747, +0.0617, -1.0097, +2.2212, -279.9075}.
  - FSM = IDLE. coef_lock = 0, coef_sel = 0, coef = 0. csr_rdata_o = 0, busy_o = 0. deferred = 0. Line counter = FRAME_HEIGHT (idle).
  - Reset mid-SEND aborts the burst. No further coef_lock is asserted.
- CSR writes:
  - csr_wr_i with addr < 12 updates shadow[addr] <= wdata[COEF_WIDTH:0]. Writes are accepted in every state.
  - Writes with addr >= 12 are ignored.
- CSR reads:
  - Registered, 1-cycle latency.
  - addr < 12 returns the zero-extended shadow value.
  - addr 12 returns {.., deferred, busy, state[1:0]}.
  - addr 13..15 returns 0.
  - csr_rdata_o holds its value when csr_rd_i = 0.
- FSM states: IDLE, WAIT_EOF, SEND.
  - IDLE + apply: staging <= shadow. Go to WAIT_EOF (macro on) or SEND (macro off) next cycle.
  - WAIT_EOF + apply: re-snapshot; latest apply wins.
  - WAIT_EOF + eof event: go to SEND.
  - SEND runs 12 cycles, idx 0..11. Outputs are registered: coef_lock = 1, coef_sel = idx, coef = staging[idx]. After idx 11 the outputs drop to 0 next cycle.
  - SEND + apply: set deferred. Staging is not touched.
  - SEND exit with deferred = 1: staging <= shadow, clear deferred, go to WAIT_EOF (macro on) or SEND (macro off).
  - SEND exit with deferred = 0: go to IDLE.
- Latency:
  - Macro off: apply at cycle N in IDLE gives coef_lock high for cycles N+1..N+12.
  - Macro on: eof event at cycle M gives coef_lock high for cycles M+1..M+12. An eof in the same cycle as the apply is not counted.
- Line counter (handshake = tvalid & tready):
  - SOF handshake sets counter = 0, or 1 if tlast is also set.
  - tlast handshake with counter < FRAME_HEIGHT increments the counter.
  - eof event = tlast handshake where counter == FRAME_HEIGHT-1. The counter then parks at FRAME_HEIGHT until the next SOF.
  - Frames shorter than FRAME_HEIGHT produce no eof. The FSM waits; a later full frame releases it.
  - Counter width is clog2(FRAME_HEIGHT+1).
- Coefficients are passed through bit-exact. No arithmetic is applied.

Optional Feature:
- Macro CC_FRAME_SYNC_EN.
- Defined: the line counter is present and FSM entry into SEND is gated by WAIT_EOF as above.
- Undefined: the counter, the WAIT_EOF state and the vid_* usage are removed; the ports remain but are ignored. Apply and deferred transitions go straight to SEND.

Decomposition:
- cc_pkg holds: COEF_NUM = 12; the coef_idx_t enum (A11..A34 = 0..11); STATUS_ADDR = 12; the state_t enum; the 12 default constants, parameterised by PX_WIDTH/FRACT_WIDTH.
- Sub-module cc_frame_tracker contains the line counter and eof pulse generation. It is instantiated only under CC_FRAME_SYNC_EN.

Test Plan:
- Reset, then read addr 0 and addr 3 -> rdata 0x007EC (+1.9808) and 0x13B35F (-236.8427) at FRACT_WIDTH = 10; all cc_ctrl outputs 0.
- Macro off: write addr 0 = 0x00400, apply at cycle N -> coef_lock for cycles N+1..N+12, sel 0..11, first coef 0x00400, the rest the defaults.
- Macro on, FRAME_HEIGHT = 4: apply mid-frame -> no coef_lock until the 4th tlast handshake; burst starts the next cycle; busy_o drops after sel 11.
- Apply during SEND after writing addr 5 = 0x00800 -> second burst after the next eof carries 0x00800 at sel 5; the first burst is unchanged.
- Two applies in WAIT_EOF with a shadow write in between -> one burst only, carrying the second snapshot.
- Deassert rst_n_i at burst sel 6 -> coef_lock is 0 on the next cycle, state reads IDLE, the shadow bank reads back as the defaults.
